// File: rtl/axi_pkg.sv
// Shared types and default widths for the AXI4-Lite memory slave.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 10;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_DEPTH  = 256;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_hold_slot.sv
// One-entry valid/ready capture register; ready is registered and mirrors !full
// except in the first cycle after reset, where it is still low.
module axi_hold_slot
  import axi_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;
  logic             w_full_nxt;

  assign w_capture  = i_valid && r_ready;
  assign w_full_nxt = w_capture || (r_full && !i_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt;
      if (w_capture) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed memory; one outstanding write
// (independent AW/W slots) and one outstanding read.
module axi_lite_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned DEPTH  = AXI_DEPTH
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned WPAY_W = DATA_W + STRB_W;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_aw_ready;
  logic              w_aw_full;
  logic [ADDR_W-1:0] w_aw_addr;
  logic              w_w_ready;
  logic              w_w_full;
  logic [WPAY_W-1:0] w_w_pay;
  logic [DATA_W-1:0] w_w_data;
  logic [STRB_W-1:0] w_w_strb;
  logic              w_commit;
  logic              w_aw_in_range;
  logic [IDX_W-1:0]  w_aw_idx;

  logic              r_bvalid;
  logic [1:0]        r_bresp;

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic              r_arready;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              w_arready_nxt;
  logic              w_rvalid_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic [1:0]        w_rresp_nxt;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_ar_in_range;
  logic [IDX_W-1:0]  w_ar_idx;

  axi_hold_slot #(.WIDTH(ADDR_W)) u_aw_slot (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_valid (AWVALID),
    .i_data  (AWADDR),
    .i_pop   (w_commit),
    .o_ready (w_aw_ready),
    .o_full  (w_aw_full),
    .o_data  (w_aw_addr)
  );

  axi_hold_slot #(.WIDTH(WPAY_W)) u_w_slot (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_valid (WVALID),
    .i_data  ({WSTRB, WDATA}),
    .i_pop   (w_commit),
    .o_ready (w_w_ready),
    .o_full  (w_w_full),
    .o_data  (w_w_pay)
  );

  assign w_w_data      = w_w_pay[DATA_W-1:0];
  assign w_w_strb      = w_w_pay[WPAY_W-1:DATA_W];
  assign w_commit      = w_aw_full && w_w_full && (!r_bvalid || BREADY);
  assign w_aw_in_range = 32'(w_aw_addr) < DEPTH;
  assign w_aw_idx      = w_aw_addr[IDX_W-1:0];

  // Memory has no reset; commit cannot fire while slots are held empty in reset.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_w_strb[b]) begin
          r_mem[w_aw_idx][8*b +: 8] <= w_w_data[8*b +: 8];
        end
      end
    end
  end

  // Write response; a commit on the B handshake edge keeps BVALID high.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_aw_in_range ? OKAY : DECERR;
    end else if (r_bvalid && BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  assign w_ar_hs       = ARVALID && r_arready;
  assign w_r_hs        = r_rvalid && RREADY;
  assign w_ar_in_range = 32'(ARADDR) < DEPTH;
  assign w_ar_idx      = ARADDR[IDX_W-1:0];

  // Read FSM: state and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (w_ar_hs) w_state_nxt = R_RESP;
      R_RESP:  if (w_r_hs)  w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Next values of the registered read-channel outputs.
  always_comb begin
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_state)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_ar_in_range ? r_mem[w_ar_idx] : '0;
          w_rresp_nxt   = w_ar_in_range ? OKAY : DECERR;
        end
      end
      R_RESP: begin
        if (w_r_hs) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
        end
      end
      default: begin
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
      end
    endcase
  end

  assign AWREADY = w_aw_ready;
  assign WREADY  = w_w_ready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: handshakes, latency, strobes, stalls, decode, reset.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [9:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [9:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n = 0;
    BREADY = 1'b1;
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    while (BVALID !== 1'b1 && n < 10) begin tick; n++; end
    total++;
    if (BVALID !== 1'b1) begin bad++; $display("FAIL wr_timeout addr=%h: BVALID=%b want 1", a, BVALID); end
    resp = BRESP;
    tick;
  endtask

  task automatic do_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    RREADY = 1'b1;
    ARADDR = a; ARVALID = 1'b1;
    tick;
    ARVALID = 1'b0;
    while (RVALID !== 1'b1 && n < 10) begin tick; n++; end
    total++;
    if (RVALID !== 1'b1) begin bad++; $display("FAIL rd_timeout addr=%h: RVALID=%b want 1", a, RVALID); end
    d = RDATA; resp = RRESP;
    tick;
    RREADY = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0;
    repeat (3) tick;
    total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      bad++; $display("FAIL rst_flags: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    total++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      bad++; $display("FAIL rst_payload: got %h/%h/%h want 0", BRESP, RRESP, RDATA);
    end
    ARESETn = 1'b1;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      bad++; $display("FAIL rst_release_ready: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    tick;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      bad++; $display("FAIL rst_first_edge_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_same_cycle;
    BREADY = 1'b1;
    AWADDR = 10'h005; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    total++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      bad++; $display("FAIL sc_capture: AWREADY,WREADY,BVALID=%b want 000", {AWREADY, WREADY, BVALID});
    end
    tick;
    total++;
    if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b1_00_11) begin
      bad++; $display("FAIL sc_commit: BVALID,BRESP,AWREADY,WREADY=%b want 10011", {BVALID, BRESP, AWREADY, WREADY});
    end
    tick;
    total++;
    if (BVALID !== 1'b0) begin bad++; $display("FAIL sc_b_done: BVALID=%b want 0", BVALID); end
    RREADY = 0; ARADDR = 10'h005; ARVALID = 1;
    tick;
    ARVALID = 0;
    total++;
    if ({RVALID, ARREADY, RRESP, RDATA} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF}) begin
      bad++; $display("FAIL sc_read: RVALID=%b ARREADY=%b RRESP=%b RDATA=%h want 1 0 00 deadbeef",
                      RVALID, ARREADY, RRESP, RDATA);
    end
    RREADY = 1;
    tick;
    total++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      bad++; $display("FAIL sc_r_done: RVALID,ARREADY=%b want 01", {RVALID, ARREADY});
    end
    RREADY = 0;
  endtask

  task automatic test_split_order;
    logic [31:0] d;
    logic [1:0]  r;
    BREADY = 1'b1;
    // W first, AW three cycles later
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
    tick;
    WVALID = 0;
    total++;
    if ({WREADY, AWREADY, BVALID} !== 3'b010) begin
      bad++; $display("FAIL wf_capture: WREADY,AWREADY,BVALID=%b want 010", {WREADY, AWREADY, BVALID});
    end
    tick; tick;
    AWADDR = 10'h006; AWVALID = 1;
    tick;
    AWVALID = 0;
    total++;
    if ({AWREADY, BVALID} !== 2'b00) begin
      bad++; $display("FAIL wf_aw_capture: AWREADY,BVALID=%b want 00", {AWREADY, BVALID});
    end
    tick;
    total++;
    if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b1_00_11) begin
      bad++; $display("FAIL wf_commit: got %b want 10011", {BVALID, BRESP, AWREADY, WREADY});
    end
    tick;
    // AW first, W three cycles later
    AWADDR = 10'h007; AWVALID = 1;
    tick;
    AWVALID = 0;
    total++;
    if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
      bad++; $display("FAIL af_capture: AWREADY,WREADY,BVALID=%b want 010", {AWREADY, WREADY, BVALID});
    end
    tick; tick;
    WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1;
    tick;
    WVALID = 0;
    total++;
    if ({WREADY, BVALID} !== 2'b00) begin
      bad++; $display("FAIL af_w_capture: WREADY,BVALID=%b want 00", {WREADY, BVALID});
    end
    tick;
    total++;
    if ({BVALID, BRESP} !== 3'b1_00) begin
      bad++; $display("FAIL af_commit: BVALID,BRESP=%b want 100", {BVALID, BRESP});
    end
    tick;
    do_read(10'h006, d, r);
    total++;
    if ({r, d} !== {2'b00, 32'h12345678}) begin bad++; $display("FAIL wf_readback: got %b/%h want 00/12345678", r, d); end
    do_read(10'h007, d, r);
    total++;
    if ({r, d} !== {2'b00, 32'h0BADF00D}) begin bad++; $display("FAIL af_readback: got %b/%h want 00/0badf00d", r, d); end
  endtask

  task automatic test_strobe;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(10'h005, 32'hAAAAAAAA, 4'b0011, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL strb_bresp: got %b want 00", r); end
    do_read(10'h005, d, r);
    total++;
    if (d !== 32'hDEADAAAA) begin bad++; $display("FAIL strb_readback: got %h want deadaaaa", d); end
    do_write(10'h005, 32'h00000000, 4'b0000, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL strb0_bresp: got %b want 00", r); end
    do_read(10'h005, d, r);
    total++;
    if (d !== 32'hDEADAAAA) begin bad++; $display("FAIL strb0_readback: got %h want deadaaaa", d); end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(10'h000, 32'h00C0FFEE, 4'hF, r);
    do_write(10'h0FF, 32'h5A5AA5A5, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL dec_last_bresp: got %b want 00", r); end
    do_write(10'h100, 32'hFFFFFFFF, 4'hF, r);
    total++;
    if (r !== 2'b11) begin bad++; $display("FAIL dec_w100_bresp: got %b want 11", r); end
    do_write(10'h300, 32'h12121212, 4'hF, r);
    total++;
    if (r !== 2'b11) begin bad++; $display("FAIL dec_w300_bresp: got %b want 11", r); end
    do_read(10'h100, d, r);
    total++;
    if ({r, d} !== {2'b11, 32'h0}) begin bad++; $display("FAIL dec_r100: got %b/%h want 11/00000000", r, d); end
    do_read(10'h3FF, d, r);
    total++;
    if ({r, d} !== {2'b11, 32'h0}) begin bad++; $display("FAIL dec_r3ff: got %b/%h want 11/00000000", r, d); end
    do_read(10'h000, d, r);
    total++;
    if ({r, d} !== {2'b00, 32'h00C0FFEE}) begin bad++; $display("FAIL dec_r000: got %b/%h want 00/00c0ffee", r, d); end
    do_read(10'h0FF, d, r);
    total++;
    if ({r, d} !== {2'b00, 32'h5A5AA5A5}) begin bad++; $display("FAIL dec_r0ff: got %b/%h want 00/5a5aa5a5", r, d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [1:0]  r;
    BREADY = 1'b0;
    AWADDR = 10'h008; AWVALID = 1; WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    total++;
    if ({BVALID, BRESP} !== 3'b1_00) begin bad++; $display("FAIL bb_first: BVALID,BRESP=%b want 100", {BVALID, BRESP}); end
    AWADDR = 10'h100; AWVALID = 1; WDATA = 32'h22222222; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b1_00_00) begin
        bad++; $display("FAIL bb_stall%0d: BVALID,BRESP,AWREADY,WREADY=%b want 10000", i, {BVALID, BRESP, AWREADY, WREADY});
      end
    end
    BREADY = 1'b1;
    tick;
    total++;
    if ({BVALID, BRESP} !== 3'b1_11) begin bad++; $display("FAIL bb_second: BVALID,BRESP=%b want 111", {BVALID, BRESP}); end
    tick;
    total++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      bad++; $display("FAIL bb_drain: BVALID,AWREADY,WREADY=%b want 011", {BVALID, AWREADY, WREADY});
    end
    do_read(10'h008, d, r);
    total++;
    if (d !== 32'h11111111) begin bad++; $display("FAIL bb_readback: got %h want 11111111", d); end
  endtask

  task automatic test_rw_collision_and_reset;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(10'h009, 32'h99990000, 4'hF, r);
    do_write(10'h00A, 32'hAAAA0000, 4'hF, r);
    BREADY = 0; RREADY = 0;
    AWADDR = 10'h009; AWVALID = 1; WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    ARADDR = 10'h009; ARVALID = 1;
    tick;
    ARVALID = 0;
    total++;
    if ({BVALID, RVALID, RDATA} !== {2'b11, 32'h99990000}) begin
      bad++; $display("FAIL col_old_data: BVALID=%b RVALID=%b RDATA=%h want 1 1 99990000", BVALID, RVALID, RDATA);
    end
    // park an AW that reset must discard
    AWADDR = 10'h00A; AWVALID = 1;
    tick;
    AWVALID = 0;
    #2 ARESETn = 1'b0;
    #1;
    total++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b0) begin
      bad++; $display("FAIL mid_rst_async: got %b want 00000", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
    tick;
    ARESETn = 1'b1;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      bad++; $display("FAIL mid_rst_release: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    tick;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      bad++; $display("FAIL mid_rst_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    BREADY = 1;
    WDATA = 32'hBAD0BAD0; WSTRB = 4'hF; WVALID = 1;
    tick;
    WVALID = 0;
    repeat (3) tick;
    total++;
    if (BVALID !== 1'b0) begin bad++; $display("FAIL mid_rst_aw_dropped: BVALID=%b want 0", BVALID); end
    AWADDR = 10'h00B; AWVALID = 1;
    tick;
    AWVALID = 0;
    tick;
    total++;
    if ({BVALID, BRESP} !== 3'b1_00) begin bad++; $display("FAIL post_rst_commit: BVALID,BRESP=%b want 100", {BVALID, BRESP}); end
    tick;
    do_read(10'h009, d, r);
    total++;
    if (d !== 32'h77777777) begin bad++; $display("FAIL col_new_data: got %h want 77777777", d); end
    do_read(10'h00A, d, r);
    total++;
    if (d !== 32'hAAAA0000) begin bad++; $display("FAIL mid_rst_no_write: got %h want aaaa0000", d); end
    do_read(10'h00B, d, r);
    total++;
    if (d !== 32'hBAD0BAD0) begin bad++; $display("FAIL post_rst_readback: got %h want bad0bad0", d); end
  endtask

  initial begin
    test_reset;
    test_same_cycle;
    test_split_order;
    test_strobe;
    test_decode;
    test_back_to_back;
    test_rw_collision_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
